// File: rtl/io_read_ctrl_pkg.sv
// Shared types and constants for the IO read controller: FSM state encoding,
// device address map and the data word returned on a keypad timeout.
package io_read_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_KP = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } rd_state_e;

    localparam logic [1:0]  ADDR_SW      = 2'd0;
    localparam logic [1:0]  ADDR_KP      = 2'd1;
    localparam logic [1:0]  ADDR_BTN     = 2'd2;
    localparam logic [1:0]  ADDR_NONE    = 2'd3;

    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;
    localparam logic [15:0] UNMAPPED_DATA = 16'h0000;

    // Zero-extend a keypad key code to a full read word.
    function automatic logic [15:0] kp_word(input logic [3:0] code);
        return {12'h000, code};
    endfunction

    // Zero-extend the five button levels to a full read word.
    function automatic logic [15:0] btn_word(input logic [4:0] btn);
        return {11'b000_0000_0000, btn};
    endfunction

endpackage

// File: rtl/io_read_ctrl_if.sv
// CPU-side IO read bus: request/address from the CPU, data/ack/err back.
// master = CPU side, slave = io_read_ctrl side.
interface io_read_ctrl_if;

    logic        req;
    logic [1:0]  addr;
    logic [15:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ack,
        output err
    );

endinterface

// File: rtl/io_read_ctrl_sync.sv
// Multi-stage level synchronizer (io_sync) for asynchronous inputs; only the
// last stage is exposed. Synchronous active-low reset clears every stage.
module io_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift chain: stage 0 captures the raw input, each later stage follows.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= {(STAGES*WIDTH){1'b0}};
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/io_read_ctrl.sv
// IO read controller: serves CPU reads of switches, keypad and buttons with a
// four-state handshake FSM. Optional keypad wait timeout: IOREAD_TIMEOUT_EN.
module io_read_ctrl
    import io_read_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    io_read_ctrl_if.slave        bus,
    input  logic [15:0]          sw_in,
    input  logic [4:0]           btn_in,
    input  logic                 kp_valid,
    input  logic [3:0]           kp_code,
    output logic                 kp_pop
);

    rd_state_e   state_q;
    rd_state_e   state_d;
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;
    logic        err_q;
    logic        err_d;
    logic [15:0] sw_sync_s;
    logic [4:0]  btn_sync_s;
    logic        tmo_expired_s;

    io_sync #(
        .WIDTH  (16),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sw_in),
        .q_o   (sw_sync_s)
    );

    io_sync #(
        .WIDTH  (5),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (btn_sync_s)
    );

`ifdef IOREAD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wait counter: runs only while parked in WAIT_KP, cleared elsewhere.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (state_q == ST_WAIT_KP) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_expired_s = (state_q == ST_WAIT_KP) &&
                           (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmo_expired_s = 1'b0;
`endif

    // State register together with the read-data and error holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; rdata/err only change on the loading transitions.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    case (bus.addr)
                        ADDR_SW: begin
                            rdata_d = sw_sync_s;
                            err_d   = 1'b0;
                            state_d = ST_ACK;
                        end
                        ADDR_BTN: begin
                            rdata_d = btn_word(btn_sync_s);
                            err_d   = 1'b0;
                            state_d = ST_ACK;
                        end
                        ADDR_KP: begin
                            state_d = ST_WAIT_KP;
                        end
                        default: begin
                            rdata_d = UNMAPPED_DATA;
                            err_d   = 1'b1;
                            state_d = ST_ACK;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_KP: begin
                // A dropped request wins over a key; a key wins over expiry.
                if (!bus.req) begin
                    state_d = ST_IDLE;
                end else if (kp_valid) begin
                    rdata_d = kp_word(kp_code);
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (tmo_expired_s) begin
                    rdata_d = TIMEOUT_DATA;
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT_KP;
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (bus.req) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; kp_pop must coincide with the load.
    always_comb begin
        bus.rdata = rdata_q;
        bus.ack   = (state_q == ST_ACK);
        bus.err   = (state_q == ST_ACK) && err_q;
        kp_pop    = reset && (state_q == ST_WAIT_KP) && bus.req && kp_valid;
    end

endmodule

// File: doc/io_read_ctrl.md
IO_READ_CTRL -- requirements
Module: io_read_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: keypad wait limit in clk cycles; only used when IOREAD_TIMEOUT_EN is defined.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on the switch and button inputs.
REQ-003 Port clk, input, 1: system clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-low.
REQ-005 Port req, input, 1: CPU IO-read request; held high until ack is seen.
REQ-006 Port addr, input, 2: device select (0 = switches, 1 = keypad, 2 = buttons, 3 = unmapped); sampled in IDLE when req is high.
REQ-007 Port sw_in, input, 16: asynchronous switch levels.
REQ-008 Port btn_in, input, 5: asynchronous button levels.
REQ-009 Port kp_valid, input, 1: keypad scanner holds a key code.
REQ-010 Port kp_code, input, 4: keypad key code; valid while kp_valid is high.
REQ-011 Port kp_pop, output, 1: one-cycle pulse that consumes the current keypad code.
REQ-012 Port rdata, output, 16: read data; stable from the ack cycle until the next accepted request.
REQ-013 Port ack, output, 1: one-cycle completion pulse.
REQ-014 Port err, output, 1: high in the ack cycle when the read failed (unmapped address or timeout); low otherwise.

Function
REQ-015 sw_in and btn_in SHALL pass through SYNC_STAGES flop stages; reads use only the final stage.
REQ-016 The FSM SHALL have exactly four states: IDLE, WAIT_KP, ACK and RELEASE.
REQ-017 IDLE with req=1 and addr=0: load rdata with the synchronized switch value and go to ACK.
REQ-018 IDLE with req=1 and addr=2: load rdata with {11'b0, synchronized buttons} and go to ACK.
REQ-019 IDLE with req=1 and addr=3: load rdata with 16'h0000, set err for the ack cycle and go to ACK.
REQ-020 IDLE with req=1 and addr=1: go to WAIT_KP.
REQ-021 WAIT_KP with kp_valid=1: load rdata with {12'b0, kp_code}, pulse kp_pop in the same cycle and go to ACK.
REQ-022 ACK: ack=1 for exactly one cycle, then go to RELEASE.
REQ-023 RELEASE: stay while req=1 and go to IDLE when req=0, so each request produces exactly one ack.
REQ-024 Latency for switch, button and unmapped reads: req sampled in IDLE at edge N, ack high during cycle N+1.
REQ-025 Latency for keypad reads: ack occurs in the cycle after kp_valid is sampled high in WAIT_KP; kp_valid already high on entry gives ack two cycles after acceptance.
REQ-026 kp_pop SHALL never assert outside WAIT_KP, and at most once per request.
REQ-027 A change of addr after acceptance SHALL be ignored until the next IDLE.
REQ-028 A req drop while in WAIT_KP SHALL abandon the read: return to IDLE with no ack and no kp_pop.
REQ-029 rdata SHALL hold its value in every state except the loading transitions above.

Reset
REQ-030 With reset=0 at a rising edge: FSM goes to IDLE; rdata=0; ack=0; err=0; kp_pop=0; synchronizer flops and timeout counter cleared.
REQ-031 Reset in any state, including mid-WAIT_KP, SHALL abort the read with no ack and no kp_pop.

Configuration
REQ-032 With macro IOREAD_TIMEOUT_EN defined: a counter runs in WAIT_KP; after TIMEOUT_CYCLES cycles without kp_valid, the FSM loads rdata=16'hFFFF, sets err and goes to ACK.
REQ-033 kp_valid arriving in the same cycle as expiry SHALL take priority, giving a normal read.
REQ-034 With IOREAD_TIMEOUT_EN undefined: WAIT_KP waits indefinitely, no counter exists, and err asserts only for addr=3.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the device address constants (ADDR_SW, ADDR_KP, ADDR_BTN) and TIMEOUT_DATA=16'hFFFF.
REQ-036 The synchronizer SHALL be one sub-module, io_sync, parameterized by width and stage count and instantiated twice.

Verification
REQ-037 Scenario: sw_in=16'hA5C3 held, then req with addr=0 -> ack one cycle after acceptance, rdata=16'hA5C3, err=0.
REQ-038 Scenario: req with addr=1 and kp_valid low, then kp_valid=1 with kp_code=4'h7 after 10 cycles -> kp_pop one cycle, rdata=16'h0007 in the next cycle with ack.
REQ-039 Scenario: req with addr=3 -> ack with rdata=16'h0000 and err=1; req held 5 more cycles -> no second ack.
REQ-040 Scenario: IOREAD_TIMEOUT_EN defined with TIMEOUT_CYCLES=16, req with addr=1 and kp_valid=0 -> ack after the 16-cycle timeout with rdata=16'hFFFF and err=1, kp_pop never asserted.
REQ-041 Scenario: reset=0 during WAIT_KP -> next cycle in IDLE, rdata=0, ack=0; a later kp_valid does not produce kp_pop.
REQ-042 Scenario: btn_in=5'b10110 toggled asynchronously, then addr=2 read -> rdata=16'h0016 once SYNC_STAGES cycles have passed since the change.
